// File: rtl/alu_pkg.sv
// Shared opcode, sub-code and state constants for the
// execute-stage ALU and its multiply/divide core.
package alu_pkg;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;

  localparam logic [3:0] LG_AND = 4'b1000;
  localparam logic [3:0] LG_OR  = 4'b1110;
  localparam logic [3:0] LG_XOR = 4'b0110;
  localparam logic [3:0] LG_NOR = 4'b0001;
  localparam logic [3:0] LG_A   = 4'b1010;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_B   = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

  localparam logic [2:0] CMP_NEQ = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_GTZ = 3'b111;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef logic [1:0] md_state_t;

  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_CALC = 2'd1;
  localparam md_state_t ST_FIX  = 2'd2;
  localparam md_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/alu_md_seq.sv
// Iterative multiply/divide core: shift-add multiply,
// restoring divide, sign fix-up and the HI/LO registers.
module alu_md_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       md_op_i,
  input  logic             md_start_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  output logic             md_ready_o,
  output logic             md_busy_o,
  output logic             md_done_o,
  output logic             md_dz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int SHW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     madd, rsh, rdiff;
  logic [2*WIDTH-1:0] p_mul, p_div, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign sgn   = md_op_i[0];
  assign a_mag = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;

  // p_q holds {acc, multiplier} or {remainder, dividend/quotient}
  assign madd  = {1'b0, p_q[2*WIDTH-1:WIDTH]}
               + (p_q[0] ? {1'b0, d_q} : '0);
  assign p_mul = {madd, p_q[WIDTH-1:1]};

  assign rsh   = p_q[2*WIDTH-1:WIDTH-1];
  assign rdiff = rsh - {1'b0, d_q};
  assign p_div = rdiff[WIDTH]
               ? {rsh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
               : {rdiff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  assign prod = neg_q ? -p_q : p_q;
  assign quo  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem  = rneg_q ? -p_q[2*WIDTH-1:WIDTH]
                       : p_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    d_d     = d_q;
    a_d     = a_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start_i) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          div_d   = md_op_i[1];
          neg_d   = sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d  = sgn & a_i[WIDTH-1];
          dz_d    = md_op_i[1] & (b_i == '0);
          a_d     = a_i;
          d_d     = b_mag;
          p_d     = {{WIDTH{1'b0}}, a_mag};
        end else begin
          if (hi_we_i) hi_d = a_i;
          if (lo_we_i) lo_d = a_i;
        end
      end
      ST_CALC: begin
        p_d   = div_q ? p_div : p_mul;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (!div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      d_q     <= d_d;
      a_q     <= a_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_ready_o = (state_q == ST_IDLE);
  assign md_busy_o  = (state_q == ST_CALC)
                    | (state_q == ST_FIX);
  assign md_done_o  = (state_q == ST_DONE);
  assign md_dz_o    = md_done_o & dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: combinational add/logic/shift/compare
// path plus the iterative multiply/divide core.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  output logic [WIDTH-1:0] Z,
  output logic             S,
  output logic             V,
  input  logic [1:0]       md_op,
  input  logic             md_start,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             md_ready,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] b_eff, sum;
  logic [WIDTH:0]   diff;
  logic             v_add, v_sub, lt_u, lt_s;
  logic             a_neg, a_zero, cmp_s;
  logic [WIDTH-1:0] logic_r, shift_r;
  logic [SHW-1:0]   shamt;

  assign b_eff = ALUFun[0] ? ~B : B;
  assign sum   = A + b_eff + WIDTH'(ALUFun[0]);
  assign v_add = (A[WIDTH-1] == b_eff[WIDTH-1])
               & (sum[WIDTH-1] != A[WIDTH-1]);

  // dedicated subtract so LT is independent of ALUFun[0]
  assign diff  = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
  assign lt_u  = ~diff[WIDTH];
  assign v_sub = (A[WIDTH-1] != B[WIDTH-1])
               & (diff[WIDTH-1] != A[WIDTH-1]);
  assign lt_s  = diff[WIDTH-1] ^ v_sub;

  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);
  assign shamt  = A[SHW-1:0];

  always_comb begin
    logic_r = '0;
    case (ALUFun[3:0])
      LG_AND:  logic_r = A & B;
      LG_OR:   logic_r = A | B;
      LG_XOR:  logic_r = A ^ B;
      LG_NOR:  logic_r = ~(A | B);
      LG_A:    logic_r = A;
      default: logic_r = '0;
    endcase
  end

  always_comb begin
    shift_r = B;
    case (ALUFun[1:0])
      SH_SLL:  shift_r = B << shamt;
      SH_SRL:  shift_r = B >> shamt;
      SH_SRA:  shift_r = $signed(B) >>> shamt;
      default: shift_r = B;
    endcase
  end

  always_comb begin
    cmp_s = 1'b0;
    case (ALUFun[3:1])
      CMP_EQ:  cmp_s = ~(|diff[WIDTH-1:0]);
      CMP_NEQ: cmp_s = |diff[WIDTH-1:0];
      CMP_LT:  cmp_s = Sign ? lt_s : lt_u;
      CMP_LEZ: cmp_s = a_neg | a_zero;
      CMP_LTZ: cmp_s = a_neg;
      CMP_GTZ: cmp_s = ~a_neg & ~a_zero;
      default: cmp_s = 1'b0;
    endcase
  end

  always_comb begin
    Z = '0;
    S = 1'b0;
    V = 1'b0;
    case (ALUFun[5:4])
      GRP_ARITH: begin
        Z = sum;
        V = Sign & v_add;
      end
      GRP_LOGIC: Z = logic_r;
      GRP_SHIFT: Z = shift_r;
      default: begin
        S = cmp_s;
        Z = {{(WIDTH-1){1'b0}}, cmp_s};
      end
    endcase
  end

  alu_md_seq #(
    .WIDTH (WIDTH)
  ) u_seq (
    .clk        (clk),
    .rst_ni     (reset),
    .a_i        (A),
    .b_i        (B),
    .md_op_i    (md_op),
    .md_start_i (md_start),
    .hi_we_i    (hi_we),
    .lo_we_i    (lo_we),
    .md_ready_o (md_ready),
    .md_busy_o  (md_busy),
    .md_done_o  (md_done),
    .md_dz_o    (md_dz),
    .hi_o       (hi),
    .lo_o       (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: random ALU vectors and MD
// ops against a 64-bit arithmetic reference, plus timing cases.
module tb_alu_md;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        reset;
  logic [31:0] A, B;
  logic [5:0]  ALUFun;
  logic        Sign;
  logic [31:0] Z;
  logic        S, V;
  logic [1:0]  md_op;
  logic        md_start, hi_we, lo_we;
  logic        md_ready, md_busy, md_done, md_dz;
  logic [31:0] hi, lo;

  logic [15:0] A16, B16, Z16, hi16, lo16;
  logic        S16, V16, start16;
  logic        rdy16, busy16, done16, dz16;

  alu_md #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .ALUFun   (ALUFun),
    .Sign     (Sign),
    .Z        (Z),
    .S        (S),
    .V        (V),
    .md_op    (md_op),
    .md_start (md_start),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .md_ready (md_ready),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .md_dz    (md_dz),
    .hi       (hi),
    .lo       (lo)
  );

  alu_md #(.WIDTH(16)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .A        (A16),
    .B        (B16),
    .ALUFun   (ALUFun),
    .Sign     (Sign),
    .Z        (Z16),
    .S        (S16),
    .V        (V16),
    .md_op    (md_op),
    .md_start (start16),
    .hi_we    (1'b0),
    .lo_we    (1'b0),
    .md_ready (rdy16),
    .md_busy  (busy16),
    .md_done  (done16),
    .md_dz    (dz16),
    .hi       (hi16),
    .lo       (lo16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void alu_ref(
    input  logic [5:0]  f,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sg,
    output logic [31:0] z,
    output logic        s,
    output logic        v
  );
    longint sa, sb, r;
    int sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(a[4:0]);
    z = 0; s = 0; v = 0;
    case (f[5:4])
      2'b00: begin
        if (f[0]) begin z = a - b; r = sa - sb; end
        else      begin z = a + b; r = sa + sb; end
        v = sg && (r > 64'sd2147483647 ||
                   r < -64'sd2147483648);
      end
      2'b01: begin
        case (f[3:0])
          4'b1000: z = a & b;
          4'b1110: z = a | b;
          4'b0110: z = a ^ b;
          4'b0001: z = ~(a | b);
          4'b1010: z = a;
          default: z = 0;
        endcase
      end
      2'b10: begin
        case (f[1:0])
          2'b00: z = b << sh;
          2'b01: z = b >> sh;
          2'b11: z = $signed(b) >>> sh;
          default: z = b;
        endcase
      end
      default: begin
        case (f[3:1])
          3'b001: s = (a == b);
          3'b000: s = (a != b);
          3'b010: s = sg ? (sa < sb) : (a < b);
          3'b110: s = (sa <= 0);
          3'b101: s = (sa < 0);
          3'b111: s = (sa > 0);
          default: s = 0;
        endcase
        z = {31'b0, s};
      end
    endcase
  endfunction

  function automatic void md_ref(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] h,
    output logic [31:0] l,
    output logic        dz
  );
    logic [63:0] pu;
    longint sa, sb, ps, q, r;
    sa = $signed(a);
    sb = $signed(b);
    dz = 0;
    case (op)
      2'b00: begin
        pu = {32'b0, a} * {32'b0, b};
        h = pu[63:32]; l = pu[31:0];
      end
      2'b01: begin
        ps = sa * sb;
        pu = ps;
        h = pu[63:32]; l = pu[31:0];
      end
      default: begin
        if (b == 0) begin
          dz = 1; h = a; l = '1;
        end else if (op == 2'b10) begin
          l = a / b; h = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          pu = q; l = pu[31:0];
          pu = r; h = pu[31:0];
        end
      end
    endcase
  endfunction

  task automatic do_md32(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          cyc,
    output logic [31:0] h,
    output logic [31:0] l,
    output logic        dz,
    output logic        busy1,
    output logic        rdy_d,
    output logic        rdy_a
  );
    A = a; B = b; md_op = op; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    busy1 = md_busy;
    cyc = 1;
    while (md_done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    h = hi; l = lo; dz = md_dz; rdy_d = md_ready;
    tick();
    rdy_a = md_ready;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    A = 0; B = 0; ALUFun = 0; Sign = 0; md_op = 0;
    md_start = 0; hi_we = 0; lo_we = 0;
    A16 = 0; B16 = 0; start16 = 0;
    tick(); tick();
    total++;
    if (hi !== 0 || lo !== 0) begin
      bad++;
      $display("FAIL reset_hilo hi=%h lo=%h want 0", hi, lo);
    end
    total++;
    if ({md_ready, md_busy, md_done, md_dz} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got=%b want 1000",
               {md_ready, md_busy, md_done, md_dz});
    end
    total++;
    if (rdy16 !== 1'b1 || hi16 !== 0 || lo16 !== 0) begin
      bad++;
      $display("FAIL reset_w16 rdy=%b hi=%h lo=%h want 1/0/0",
               rdy16, hi16, lo16);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu_directed();
    A = 32'h7FFFFFFF; B = 1; ALUFun = 6'b000000; Sign = 1;
    #1;
    total++;
    if (Z !== 32'h80000000 || V !== 1'b1) begin
      bad++;
      $display("FAIL add_ovf Z=%h V=%b want 80000000/1", Z, V);
    end
    A = 4; B = 32'h80000000; ALUFun = 6'b100011;
    #1;
    total++;
    if (Z !== 32'hF8000000) begin
      bad++;
      $display("FAIL sra Z=%h want f8000000", Z);
    end
    A = 32'h80000000; B = 1; ALUFun = 6'b110100; Sign = 0;
    #1;
    total++;
    if (S !== 1'b0) begin
      bad++;
      $display("FAIL lt_unsigned S=%b want 0", S);
    end
    Sign = 1;
    #1;
    total++;
    if (S !== 1'b1) begin
      bad++;
      $display("FAIL lt_signed S=%b want 1", S);
    end
  endtask

  task automatic test_alu_random();
    logic [5:0] codes [17] = '{
      6'h00, 6'h01, 6'h18, 6'h1E, 6'h16, 6'h11, 6'h1A,
      6'h20, 6'h21, 6'h23, 6'h22,
      6'h30, 6'h32, 6'h34, 6'h3C, 6'h3A, 6'h3E};
    logic [31:0] ez;
    logic es, ev;
    for (int i = 0; i < 400; i++) begin
      ALUFun = ($urandom_range(0, 3) != 0)
             ? codes[$urandom_range(0, 16)]
             : 6'($urandom_range(0, 63));
      A = $urandom; B = $urandom;
      Sign = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: B = A;
        1: A = 0;
        2: begin A = 32'h7FFFFFFF; B = 32'hFFFFFFFF; end
        3: begin A = 32'h80000000; B = 1; end
        default: ;
      endcase
      if (ALUFun[5:4] == 2'b11 && ALUFun[3:1] >= 3'b101)
        Sign = 1;
      #1;
      alu_ref(ALUFun, A, B, Sign, ez, es, ev);
      total++;
      if (Z !== ez) begin
        bad++;
        $display("FAIL alu_z f=%b a=%h b=%h Z=%h want %h",
                 ALUFun, A, B, Z, ez);
      end
      if (ALUFun[5:4] == 2'b00) begin
        total++;
        if (V !== ev) begin
          bad++;
          $display("FAIL alu_v f=%b a=%h b=%h s=%b V=%b want %b",
                   ALUFun, A, B, Sign, V, ev);
        end
      end
      if (ALUFun[5:4] == 2'b11) begin
        total++;
        if (S !== es) begin
          bad++;
          $display("FAIL alu_s f=%b a=%h b=%h S=%b want %b",
                   ALUFun, A, B, S, es);
        end
      end
    end
  endtask

  task automatic test_md_directed();
    int cyc;
    logic [31:0] h, l;
    logic dz, b1, rd, ra;
    do_md32(2'b01, -32'sd3, 32'd7, cyc, h, l, dz, b1, rd, ra);
    total++;
    if (cyc !== 34) begin
      bad++;
      $display("FAIL mult_latency cyc=%0d want 34", cyc);
    end
    total++;
    if (b1 !== 1'b1 || rd !== 1'b0 || ra !== 1'b1) begin
      bad++;
      $display("FAIL mult_hs busy1=%b rdy_done=%b rdy_after=%b",
               b1, rd, ra);
    end
    total++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB) begin
      bad++;
      $display("FAIL mult hi=%h lo=%h want ffffffff/ffffffeb",
               h, l);
    end
    do_md32(2'b00, -32'sd3, 32'd7, cyc, h, l, dz, b1, rd, ra);
    total++;
    if (h !== 32'd6 || l !== 32'hFFFFFFEB) begin
      bad++;
      $display("FAIL multu hi=%h lo=%h want 6/ffffffeb", h, l);
    end
    do_md32(2'b11, -32'sd7, 32'd2, cyc, h, l, dz, b1, rd, ra);
    total++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD || dz !== 0) begin
      bad++;
      $display("FAIL div hi=%h lo=%h dz=%b want ffffffff/fffffffd/0",
               h, l, dz);
    end
    do_md32(2'b10, 32'd7, 32'd0, cyc, h, l, dz, b1, rd, ra);
    total++;
    if (h !== 32'd7 || l !== 32'hFFFFFFFF || dz !== 1 ||
        cyc !== 34) begin
      bad++;
      $display("FAIL divu_dz hi=%h lo=%h dz=%b cyc=%0d",
               h, l, dz, cyc);
    end
    total++;
    if (md_dz !== 1'b0) begin
      bad++;
      $display("FAIL dz_pulse md_dz=%b after done want 0", md_dz);
    end
    do_md32(2'b11, 32'h80000000, 32'hFFFFFFFF,
            cyc, h, l, dz, b1, rd, ra);
    total++;
    if (h !== 0 || l !== 32'h80000000 || dz !== 0) begin
      bad++;
      $display("FAIL div_min hi=%h lo=%h dz=%b want 0/80000000/0",
               h, l, dz);
    end
  endtask

  task automatic test_md_random();
    int cyc;
    logic [31:0] h, l, eh, el, a, b;
    logic dz, edz, b1, rd, ra;
    logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h80000000; b = '1; end
        2: begin
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      md_ref(op, a, b, eh, el, edz);
      do_md32(op, a, b, cyc, h, l, dz, b1, rd, ra);
      total++;
      if (h !== eh || l !== el || dz !== edz || cyc !== 34) begin
        bad++;
        $display("FAIL md_rand op=%0d a=%h b=%h got %h/%h/%b/%0d want %h/%h/%b/34",
                 op, a, b, h, l, dz, cyc, eh, el, edz);
      end
    end
  endtask

  task automatic test_handshake();
    int cyc, dones, done_at;
    logic [31:0] h, l;
    logic dz, b1, rd, ra;
    A = -32'sd3; B = 7; md_op = 2'b01; md_start = 1;
    tick();
    md_start = 0;
    dones = 0; done_at = 0;
    for (int c = 1; c < 60; c++) begin
      if (md_done === 1'b1) begin
        dones++;
        if (done_at == 0) done_at = c;
      end
      if (c == 5) begin
        A = 100; B = 100; md_op = 2'b00; md_start = 1;
      end else if (c == 8) begin
        A = 32'h1234; hi_we = 1;
      end else begin
        md_start = 0; hi_we = 0;
      end
      tick();
    end
    total++;
    if (dones !== 1 || done_at !== 34) begin
      bad++;
      $display("FAIL restart_ignored dones=%0d at=%0d want 1 at 34",
               dones, done_at);
    end
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      bad++;
      $display("FAIL busy_write hi=%h lo=%h want ffffffff/ffffffeb",
               hi, lo);
    end
    A = 32'h1234; hi_we = 1;
    tick();
    hi_we = 0;
    total++;
    if (hi !== 32'h1234) begin
      bad++;
      $display("FAIL idle_hi_we hi=%h want 1234", hi);
    end
    A = 32'h5678; lo_we = 1;
    tick();
    lo_we = 0;
    total++;
    if (lo !== 32'h5678 || hi !== 32'h1234) begin
      bad++;
      $display("FAIL idle_lo_we hi=%h lo=%h want 1234/5678", hi, lo);
    end
    A = 5; B = 6; md_op = 2'b00; md_start = 1; hi_we = 1; lo_we = 1;
    tick();
    md_start = 0; hi_we = 0; lo_we = 0;
    total++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      bad++;
      $display("FAIL start_wins hi=%h lo=%h want 1234/5678", hi, lo);
    end
    cyc = 1;
    while (md_done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    total++;
    if (hi !== 0 || lo !== 30 || cyc !== 34) begin
      bad++;
      $display("FAIL start_wins_res hi=%h lo=%h cyc=%0d want 0/1e/34",
               hi, lo, cyc);
    end
    tick();
    do_md32(2'b10, 32'd100, 32'd7, cyc, h, l, dz, b1, rd, ra);
    do_md32(2'b01, 32'd9, -32'sd9, cyc, h, l, dz, b1, rd, ra);
    total++;
    if (cyc !== 34 || h !== 32'hFFFFFFFF || l !== 32'hFFFFFFAF) begin
      bad++;
      $display("FAIL back_to_back cyc=%0d hi=%h lo=%h want 34/ffffffff/ffffffaf",
               cyc, h, l);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    A = 32'hAAAA; hi_we = 1; lo_we = 1;
    tick();
    hi_we = 0; lo_we = 0;
    A = -32'sd7; B = 2; md_op = 2'b11; md_start = 1;
    tick();
    md_start = 0;
    for (int c = 1; c < 10; c++) tick();
    reset = 0;
    tick();
    reset = 1;
    total++;
    if (md_ready !== 1'b1 || md_busy !== 1'b0 ||
        hi !== 0 || lo !== 0) begin
      bad++;
      $display("FAIL reset_mid rdy=%b busy=%b hi=%h lo=%h want 1/0/0/0",
               md_ready, md_busy, hi, lo);
    end
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      if (md_done === 1'b1) dones++;
      tick();
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_mid_done dones=%0d want 0", dones);
    end
  endtask

  task automatic test_width16();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      A16 = 16'hFFFD; B16 = 7;
      md_op = (k == 0) ? 2'b01 : 2'b00;
      start16 = 1;
      tick();
      start16 = 0;
      cyc = 1;
      while (done16 !== 1'b1 && cyc < 100) begin
        tick();
        cyc++;
      end
      total++;
      if (cyc !== 18 || lo16 !== 16'hFFEB ||
          hi16 !== ((k == 0) ? 16'hFFFF : 16'h0006)) begin
        bad++;
        $display("FAIL w16_mult op=%0d cyc=%0d hi=%h lo=%h",
                 md_op, cyc, hi16, lo16);
      end
      tick();
      total++;
      if (rdy16 !== 1'b1) begin
        bad++;
        $display("FAIL w16_ready rdy=%b want 1", rdy16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_md_directed();
    test_md_random();
    test_handshake();
    test_reset_mid();
    test_width16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
